// File: rtl/atm_pin_verifier.sv
// atm_pin_verifier: collects keypad PIN digits and checks them against the
// card's stored PIN. It enforces a retry limit, an inactivity timeout and a
// lockout that keeps the card. It drives pin_correct to the ATM controller.
module atm_pin_verifier #(
   parameter int PIN_DIGITS  = 4,
   parameter int MAX_TRIES   = 3,
   parameter int TIMEOUT_CYC = 1000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    card_inserted,
   input  logic                    key_valid,
   input  logic [3:0]              key_digit,
   input  logic                    key_enter,
   input  logic                    key_clear,
   input  logic [4*PIN_DIGITS-1:0] stored_pin,
   output logic                    pin_correct,
   output logic                    pin_fail,
   output logic                    card_retain,
   output logic [2:0]              tries_left,
   output logic [3:0]              digit_count
);

   localparam int         BW  = 4 * PIN_DIGITS;
   localparam int         TW  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [3:0] PD4 = 4'(PIN_DIGITS);

   typedef enum logic [2:0] {
      S_IDLE, S_ENTRY, S_VERIFY, S_GRANTED, S_LOCKED
   } state_t;

   state_t          state_q, state_d;
   logic [BW-1:0]   buf_q, buf_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [TW-1:0]   idle_q, idle_d;
   logic [2:0]      tries_q, tries_d;
   logic            fail_q, fail_d;
   logic            correct_q, correct_d;
   logic            retain_q, retain_d;
   logic            do_fail;

   // Next-state logic: card removal beats every key event. A timeout and a
   // VERIFY mismatch share one failure path.
   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      cnt_d   = cnt_q;
      idle_d  = idle_q;
      tries_d = tries_q;
      fail_d  = 1'b0;
      do_fail = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (card_inserted) begin
               state_d = S_ENTRY;
               tries_d = 3'(MAX_TRIES);
               buf_d   = '0;
               cnt_d   = '0;
               idle_d  = '0;
            end
         end
         S_ENTRY: begin
            if (!card_inserted) begin
               state_d = S_IDLE;
               buf_d   = '0;
               cnt_d   = '0;
               idle_d  = '0;
            end else if (key_clear) begin
               buf_d  = '0;
               cnt_d  = '0;
               idle_d = '0;
            end else if (key_enter) begin
               state_d = S_VERIFY;
               idle_d  = '0;
            end else if (key_valid) begin
               idle_d = '0;
               // Non-BCD codes and digits past a full buffer are dropped.
               if (key_digit <= 4'd9 && cnt_q < PD4) begin
                  buf_d = (buf_q << 4) | BW'(key_digit);
                  cnt_d = cnt_q + 4'd1;
               end
            end else if (idle_q == TW'(TIMEOUT_CYC - 1)) begin
               do_fail = 1'b1;
            end else begin
               idle_d = idle_q + 1'b1;
            end
         end
         S_VERIFY: begin
            if (!card_inserted) begin
               state_d = S_IDLE;
               buf_d   = '0;
               cnt_d   = '0;
               idle_d  = '0;
            end else if (cnt_q == PD4 && buf_q == stored_pin) begin
               state_d = S_GRANTED;
            end else begin
               do_fail = 1'b1;
            end
         end
         S_GRANTED: begin
            if (!card_inserted) begin
               state_d = S_IDLE;
               buf_d   = '0;
               cnt_d   = '0;
               idle_d  = '0;
            end
         end
         default: ;  // S_LOCKED: only reset leaves
      endcase

      // A failed attempt always wipes the entered digits, also on lockout.
      if (do_fail) begin
         fail_d  = 1'b1;
         tries_d = tries_q - 3'd1;
         buf_d   = '0;
         cnt_d   = '0;
         idle_d  = '0;
         state_d = (tries_d == 3'd0) ? S_LOCKED : S_ENTRY;
      end

      correct_d = (state_d == S_GRANTED);
      retain_d  = (state_d == S_LOCKED);
   end

   // All state and registered outputs; reset also releases a lockout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         buf_q     <= '0;
         cnt_q     <= '0;
         idle_q    <= '0;
         tries_q   <= '0;
         fail_q    <= 1'b0;
         correct_q <= 1'b0;
         retain_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         buf_q     <= buf_d;
         cnt_q     <= cnt_d;
         idle_q    <= idle_d;
         tries_q   <= tries_d;
         fail_q    <= fail_d;
         correct_q <= correct_d;
         retain_q  <= retain_d;
      end
   end

   assign pin_correct = correct_q;
   assign pin_fail    = fail_q;
   assign card_retain = retain_q;
   assign tries_left  = tries_q;
   assign digit_count = cnt_q;

endmodule

// File: tb/tb_atm_pin_verifier.sv
// Bench for atm_pin_verifier: directed scenarios, then random keypad traffic.
// Each cycle is checked against a digit-queue reference model.
module tb_atm_pin_verifier;
   localparam int PD = 4;
   localparam int MT = 3;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          card_inserted = 1'b0, key_valid = 1'b0, key_enter = 1'b0, key_clear = 1'b0;
   logic [3:0]    key_digit = 4'd0;
   logic [4*PD-1:0] stored_pin = 16'h1234;
   logic          pin_correct, pin_fail, card_retain;
   logic [2:0]    tries_left;
   logic [3:0]    digit_count;

   int n_tests = 0;
   int n_fail  = 0;

   atm_pin_verifier #(.PIN_DIGITS(PD), .MAX_TRIES(MT), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst_n(rst_n), .card_inserted(card_inserted),
      .key_valid(key_valid), .key_digit(key_digit), .key_enter(key_enter),
      .key_clear(key_clear), .stored_pin(stored_pin),
      .pin_correct(pin_correct), .pin_fail(pin_fail), .card_retain(card_retain),
      .tries_left(tries_left), .digit_count(digit_count));

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef enum {P_IDLE, P_ENTRY, P_VERIFY, P_GRANT, P_LOCK} phase_t;
   phase_t m_ph = P_IDLE;
   int     m_q[$];
   int     m_idle = 0;
   int     m_tries = 0;
   bit     m_fail = 0;

   function automatic bit pin_matches();
      if (m_q.size() != PD) return 0;
      for (int i = 0; i < PD; i++)
         if (m_q[i] != int'(stored_pin[(PD-1-i)*4 +: 4])) return 0;
      return 1;
   endfunction

   task automatic attempt_failed();
      m_fail = 1;
      m_tries--;
      m_q.delete();
      m_idle = 0;
      m_ph = (m_tries == 0) ? P_LOCK : P_ENTRY;
   endtask

   task automatic model_reset();
      m_ph = P_IDLE; m_q.delete(); m_idle = 0; m_tries = 0; m_fail = 0;
   endtask

   task automatic model_step();
      m_fail = 0;
      if (m_ph != P_IDLE && m_ph != P_LOCK && !card_inserted) begin
         m_ph = P_IDLE; m_q.delete(); m_idle = 0;
      end else begin
         case (m_ph)
            P_IDLE: if (card_inserted) begin
               m_ph = P_ENTRY; m_tries = MT; m_q.delete(); m_idle = 0;
            end
            P_ENTRY: begin
               if (key_clear) begin m_q.delete(); m_idle = 0; end
               else if (key_enter) begin m_ph = P_VERIFY; m_idle = 0; end
               else if (key_valid) begin
                  m_idle = 0;
                  if (key_digit < 10 && m_q.size() < PD) m_q.push_back(int'(key_digit));
               end
               else if (m_idle == TO - 1) attempt_failed();
               else m_idle++;
            end
            P_VERIFY: if (pin_matches()) m_ph = P_GRANT; else attempt_failed();
            default: ;
         endcase
      end
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".correct"}, int'(pin_correct), int'(m_ph == P_GRANT));
      chk({tag, ".retain"},  int'(card_retain), int'(m_ph == P_LOCK));
      chk({tag, ".fail"},    int'(pin_fail),    int'(m_fail));
      chk({tag, ".tries"},   int'(tries_left),  m_tries);
      chk({tag, ".count"},   int'(digit_count), m_q.size());
   endtask

   // One clock: drive inputs, take the edge, advance model, check 1 time unit later.
   task automatic cyc(input bit c, input bit v, input logic [3:0] d, input bit e, input bit cl);
      card_inserted = c; key_valid = v; key_digit = d; key_enter = e; key_clear = cl;
      @(posedge clk);
      model_step();
      #1;
      check_all("cyc");
   endtask

   task automatic key(input logic [3:0] d); cyc(1, 1, d, 0, 0); endtask
   task automatic enter();                  cyc(1, 0, 4'd0, 1, 0); endtask
   task automatic clr();                    cyc(1, 0, 4'd0, 0, 1); endtask
   task automatic idle();                   cyc(1, 0, 4'd0, 0, 0); endtask
   task automatic remove();                 cyc(0, 0, 4'd0, 0, 0); endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all("rst_async");
      @(posedge clk);
      #1;
      check_all("rst_hold");
      rst_n = 1'b1;
   endtask

   task automatic type_pin(input logic [15:0] p);
      for (int i = PD - 1; i >= 0; i--) key(p[i*4 +: 4]);
   endtask

   initial begin
      #2;
      do_reset();
      chk("reset.tries", int'(tries_left), 0);

      // 1: correct PIN granted two edges after enter
      stored_pin = 16'h1234;
      idle();
      chk("s1.tries_init", int'(tries_left), 3);
      type_pin(16'h1234);
      enter();
      chk("s1.not_yet", int'(pin_correct), 0);
      idle();
      chk("s1.granted", int'(pin_correct), 1);
      chk("s1.nofail", int'(pin_fail), 0);
      key(4'd7);                      // keypad ignored while granted
      chk("s1.keys_ignored", int'(digit_count), 4);

      // 6a: removal in GRANTED drops pin_correct next edge
      remove();
      chk("s6.removed", int'(pin_correct), 0);

      // 2: three wrong attempts lock the card
      idle();
      for (int t = 0; t < 3; t++) begin
         type_pin(16'h1235);
         enter();
         idle();
         chk("s2.fail_pulse", int'(pin_fail), 1);
         chk("s2.tries", int'(tries_left), 2 - t);
      end
      chk("s2.retain", int'(card_retain), 1);
      type_pin(16'h1234);
      enter();
      idle();
      remove();
      chk("s2.locked_ignores", int'(pin_correct), 0);
      chk("s2.still_retain", int'(card_retain), 1);

      // 6b: reset while locked
      do_reset();
      chk("s6.retain_clr", int'(card_retain), 0);

      // 3: clear then correct PIN; short PIN fails
      idle();
      key(4'd9); key(4'd9);
      clr();
      chk("s3.cleared", int'(digit_count), 0);
      type_pin(16'h1234);
      enter(); idle();
      chk("s3.granted", int'(pin_correct), 1);
      remove(); idle();
      key(4'd1); key(4'd2); key(4'd3);
      enter(); idle();
      chk("s3.short_fail", int'(pin_fail), 1);
      chk("s3.short_tries", int'(tries_left), 2);

      // 4: overflow digit and non-BCD digit ignored
      remove(); idle();
      type_pin(16'h1234);
      key(4'd5);
      chk("s4.full", int'(digit_count), 4);
      key(4'hA);
      enter(); idle();
      chk("s4.granted", int'(pin_correct), 1);

      // 5: inactivity timeout
      remove(); idle();
      key(4'd1);
      for (int i = 0; i < TO - 1; i++) idle();
      chk("s5.no_early_fail", int'(pin_fail), 0);
      idle();
      chk("s5.timeout_fail", int'(pin_fail), 1);
      chk("s5.tries", int'(tries_left), 2);
      chk("s5.count", int'(digit_count), 0);

      // random traffic
      begin
         int quiet = 0;
         for (int n = 0; n < 4000; n++) begin
            bit c, v, e, cl;
            logic [3:0] d;
            if (m_ph == P_LOCK && $urandom_range(0, 19) == 0) begin
               do_reset();
               continue;
            end
            if (m_ph == P_IDLE) begin
               for (int i = 0; i < PD; i++) stored_pin[i*4 +: 4] = 4'($urandom_range(0, 9));
               c = ($urandom_range(0, 1) == 1);
            end else begin
               c = ($urandom_range(0, 99) < 98);
            end
            if (quiet == 0 && $urandom_range(0, 99) < 3) quiet = $urandom_range(10, 20);
            if (quiet > 0) begin
               quiet--;
               v = 0; e = 0; cl = 0;
            end else begin
               v  = ($urandom_range(0, 99) < 35);
               e  = ($urandom_range(0, 99) < 6);
               cl = ($urandom_range(0, 99) < 3);
            end
            if (m_q.size() < PD && $urandom_range(0, 99) < 70)
               d = stored_pin[(PD-1-m_q.size())*4 +: 4];
            else
               d = 4'($urandom_range(0, 15));
            cyc(c, v, d, e, cl);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
